// File: rtl/gpio_panel_ctrl.sv
// gpio_panel_ctrl
// ----------------
// This block is a small front-panel controller that sits on a processor GPIO pair.
// The processor writes a command word on i_gpo. The block drives LEDs, debounces
// DIP switches and reports status back on o_gpi.
//
// Command handshake: a command is issued by inverting i_gpo[31] while
// opcode/address/data are presented in the same word. Each change of bit 31
// relative to its registered previous value is exactly one command, executed
// on that clock edge. There is no back-pressure. The processor confirms
// execution by watching the ack counter in o_gpi[23:16]. The ack counter
// counts only valid commands.
//
// Command word: [31] strobe toggle, [30:28] opcode, [27:24] address, [23:0] data
//   op 0 SET_MODE   LED[address] mode = data[1:0] (off/on/blink/blink-inverted)
//   op 1 SET_PERIOD blink period = data, prescaler and phase restart
//   op 2 CLR_FLAGS  clear switch change flags selected by data[N_SW-1:0]
//   op 3 SET_DEB    debounce limit = data, all debounce counters restart
//   op 4..7         ignored
//
// Ports:
//   i_clock    single clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_gpo      command word from the processor (synchronous to i_clock)
//   o_gpi      status word: [N_SW-1:0] debounced switches, [8+:N_SW] change
//              flags, [23:16] ack counter, [24] blink phase, others 0
//   i_sw       raw asynchronous switches
//   o_led      registered LED drive
module gpio_panel_ctrl #(
  parameter int                   NB_GPIOS      = 32,
  parameter int                   N_LEDS        = 8,
  parameter int                   N_SW          = 4,
  parameter int                   NB_TIMER      = 24,
  parameter logic [NB_TIMER-1:0]  BLINK_DEFAULT = NB_TIMER'(5000000),
  parameter logic [NB_TIMER-1:0]  DEB_DEFAULT   = NB_TIMER'(100000)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [NB_GPIOS-1:0] i_gpo,
  output logic [NB_GPIOS-1:0] o_gpi,
  input  logic [N_SW-1:0]     i_sw,
  output logic [N_LEDS-1:0]   o_led
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BINV  = 2'b11;

  // ---------------- command decode ----------------
  logic                r_strobe_prev;
  logic                w_cmd;
  logic [2:0]          w_op;
  logic [3:0]          w_addr;
  logic [23:0]         w_data;
  logic                w_addr_ok;
  logic                w_set_mode;
  logic                w_set_period;
  logic                w_clr_flags;
  logic                w_set_deb;
  logic                w_valid;
  logic [N_SW-1:0]     w_clr_mask;

  assign w_cmd        = i_gpo[31] ^ r_strobe_prev;
  assign w_op         = i_gpo[30:28];
  assign w_addr       = i_gpo[27:24];
  assign w_data       = i_gpo[23:0];
  assign w_addr_ok    = ({28'd0, w_addr} < 32'(N_LEDS));
  assign w_set_mode   = w_cmd && (w_op == 3'd0) && w_addr_ok;
  assign w_set_period = w_cmd && (w_op == 3'd1);
  assign w_clr_flags  = w_cmd && (w_op == 3'd2);
  assign w_set_deb    = w_cmd && (w_op == 3'd3);
  assign w_valid      = w_set_mode || w_set_period || w_clr_flags || w_set_deb;
  assign w_clr_mask   = w_clr_flags ? w_data[N_SW-1:0] : '0;

  // ---------------- registers ----------------
  logic [1:0]          r_mode [N_LEDS];
  logic [N_LEDS-1:0]   r_led;
  logic [NB_TIMER-1:0] r_period;
  logic [NB_TIMER-1:0] r_pre_cnt;
  logic                r_phase;
  logic [NB_TIMER-1:0] r_limit;
  logic [N_SW-1:0]     r_sync1;
  logic [N_SW-1:0]     r_sync2;
  logic [NB_TIMER-1:0] r_deb_cnt [N_SW];
  logic [N_SW-1:0]     r_deb;
  logic [N_SW-1:0]     r_flags;
  logic [7:0]          r_ack;
  logic [NB_GPIOS-1:0] r_gpi;

  logic [N_LEDS-1:0]   w_led_next;
  logic [N_SW-1:0]     w_deb_set;
  logic [NB_GPIOS-1:0] w_gpi_next;

  // Strobe history and ack counter
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_strobe_prev <= 1'b0;
      r_ack         <= 8'd0;
    end else begin
      r_strobe_prev <= i_gpo[31];
      if (w_valid) r_ack <= r_ack + 8'd1;
    end
  end

  // LED modes
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < N_LEDS; k++) r_mode[k] <= MODE_OFF;
    end else if (w_set_mode) begin
      for (int k = 0; k < N_LEDS; k++) begin
        if (w_addr == 4'(k)) r_mode[k] <= w_data[1:0];
      end
    end
  end

  // Blink prescaler: counts 0..period inclusive, so the phase half-period
  // is period+1 cycles and period 0 toggles every cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_period  <= BLINK_DEFAULT;
      r_pre_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_set_period) begin
      r_period  <= w_data[NB_TIMER-1:0];
      r_pre_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (r_pre_cnt == r_period) begin
      r_pre_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_pre_cnt <= r_pre_cnt + NB_TIMER'(1);
    end
  end

  always_comb begin
    w_led_next = '0;
    for (int k = 0; k < N_LEDS; k++) begin
      case (r_mode[k])
        MODE_OFF:   w_led_next[k] = 1'b0;
        MODE_ON:    w_led_next[k] = 1'b1;
        MODE_BLINK: w_led_next[k] = r_phase;
        MODE_BINV:  w_led_next[k] = ~r_phase;
        default:    w_led_next[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_led <= '0;
    else            r_led <= w_led_next;
  end

  assign o_led = r_led;

  // Switch synchronizer
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // A switch commits when it has disagreed with the debounced state while
  // the counter already sits at the limit. With limit 0, the switch commits
  // on the first cycle it disagrees. A SET_DEB command restarts all switches,
  // so nothing commits in that cycle.
  always_comb begin
    w_deb_set = '0;
    for (int i = 0; i < N_SW; i++) begin
      w_deb_set[i] = !w_set_deb && (r_sync2[i] != r_deb[i]) &&
                     (r_deb_cnt[i] == r_limit);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_limit <= DEB_DEFAULT;
      r_deb   <= '0;
      for (int i = 0; i < N_SW; i++) r_deb_cnt[i] <= '0;
    end else if (w_set_deb) begin
      r_limit <= w_data[NB_TIMER-1:0];
      for (int i = 0; i < N_SW; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (w_deb_set[i]) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + NB_TIMER'(1);
        end
      end
    end
  end

  // Sticky change flags: a new edge beats a simultaneous clear
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_flags <= '0;
    else            r_flags <= (r_flags & ~w_clr_mask) | w_deb_set;
  end

  // Status word
  always_comb begin
    w_gpi_next              = '0;
    w_gpi_next[N_SW-1:0]    = r_deb;
    w_gpi_next[8 +: N_SW]   = r_flags;
    w_gpi_next[23:16]       = r_ack;
    w_gpi_next[24]          = r_phase;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_gpi <= '0;
    else            r_gpi <= w_gpi_next;
  end

  assign o_gpi = r_gpi;

endmodule

// File: tb/tb_gpio_panel_ctrl.sv
// Testbench for gpio_panel_ctrl (default parameters).
module tb_gpio_panel_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpo;
  logic [31:0] gpi;
  logic [3:0]  sw;
  logic [7:0]  led;

  int          checks;
  int          errors;
  int          cyc;
  logic        tgl;
  logic [7:0]  exp_ack;

  gpio_panel_ctrl dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_gpo     (gpo),
    .o_gpi     (gpi),
    .i_sw      (sw),
    .o_led     (led)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command; applied on the next rising edge.
  task automatic send_cmd(input logic [2:0] op, input logic [3:0] addr, input logic [23:0] data);
    tgl = ~tgl;
    gpo = {tgl, op, addr, data};
    if (op == 3'd1 || op == 3'd2 || op == 3'd3 || (op == 3'd0 && addr < 4'd8))
      exp_ack = exp_ack + 8'd1;
    tick();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  addr;
    logic [23:0] data;
    logic [7:0]  exp_led;
    logic [7:0]  exp_ack;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  ph;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    tgl     = 1'b0;
    exp_ack = 8'd0;

    // Blink period is at its 5M default throughout the table, so phase = 0:
    // blink shows 0 and blink-inverted shows 1.
    vecs[0]  = '{3'd0, 4'd2,  24'd1, 8'h04, 8'd1};  // 0x8200_0001
    vecs[1]  = '{3'd0, 4'd0,  24'd1, 8'h05, 8'd2};
    vecs[2]  = '{3'd0, 4'd7,  24'd3, 8'h85, 8'd3};
    vecs[3]  = '{3'd0, 4'd2,  24'd0, 8'h81, 8'd4};
    vecs[4]  = '{3'd5, 4'd0,  24'd1, 8'h81, 8'd4};  // opcode 5 ignored
    vecs[5]  = '{3'd0, 4'd12, 24'd1, 8'h81, 8'd4};  // address out of range
    vecs[6]  = '{3'd0, 4'd8,  24'd1, 8'h81, 8'd4};  // first invalid address
    vecs[7]  = '{3'd0, 4'd3,  24'd2, 8'h81, 8'd5};
    vecs[8]  = '{3'd0, 4'd7,  24'd0, 8'h01, 8'd6};
    vecs[9]  = '{3'd0, 4'd0,  24'd0, 8'h00, 8'd7};
    vecs[10] = '{3'd0, 4'd3,  24'd0, 8'h00, 8'd8};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    gpo   = 32'h0;
    sw    = 4'h0;
    #2;
    check("reset_led", {24'h0, led}, 32'h0);
    check("reset_gpi", gpi, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_gpi", gpi, 32'h0);

    // ---------------- table-driven commands ----------------
    for (int i = 0; i < 11; i++) begin
      send_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
      tick();
      check($sformatf("vec%0d_led", i), {24'h0, led}, {24'h0, vecs[i].exp_led});
      check($sformatf("vec%0d_ack", i), {24'h0, gpi[23:16]}, {24'h0, vecs[i].exp_ack});
    end

    // ---------------- blink, period 3 ----------------
    send_cmd(3'd1, 4'd0, 24'd3);
    n = cyc;                            // edge index where phase restarts
    send_cmd(3'd0, 4'd0, 24'd2);
    send_cmd(3'd0, 4'd1, 24'd3);
    tick();
    for (int j = 0; j < 12; j++) begin
      // output after edge P+m reflects phase after edge P+m-1 = ((m-1)/4)%2
      ph = (((cyc - n - 1) / 4) % 2) != 0;
      check("blink_p3_led", {24'h0, led}, {24'h0, 6'b0, ~ph, ph});
      check("blink_p3_gpi24", {31'h0, gpi[24]}, {31'h0, ph});
      tick();
    end

    // ---------------- blink, period 0 ----------------
    send_cmd(3'd1, 4'd0, 24'd0);
    n = cyc;
    tick();
    for (int j = 0; j < 4; j++) begin
      ph = ((cyc - n - 1) % 2) != 0;
      check("blink_p0_led", {24'h0, led}, {24'h0, 6'b0, ~ph, ph});
      tick();
    end

    // ---------------- debounce with glitch ----------------
    send_cmd(3'd3, 4'd0, 24'd10);
    sw = 4'b0001;
    repeat (5) tick();
    sw = 4'b0000;
    repeat (15) tick();
    check("glitch_deb", {31'h0, gpi[0]}, 32'h0);
    check("glitch_flag", {31'h0, gpi[8]}, 32'h0);
    sw = 4'b0001;
    repeat (13) tick();
    check("deb_early", {31'h0, gpi[0]}, 32'h0);
    tick();
    check("deb_rise", {31'h0, gpi[0]}, 32'h1);
    check("deb_flag", {31'h0, gpi[8]}, 32'h1);

    // ---------------- clear vs. set collision ----------------
    sw = 4'b0000;
    repeat (12) tick();
    send_cmd(3'd2, 4'd0, 24'h1);        // lands on the edge that commits the fall
    tick();
    check("clr_collide_deb", {31'h0, gpi[0]}, 32'h0);
    check("clr_collide_flag", {31'h0, gpi[8]}, 32'h1);
    send_cmd(3'd2, 4'd0, 24'h1);
    tick();
    check("clr_plain_flag", {31'h0, gpi[8]}, 32'h0);
    check("ack_after_clr", {24'h0, gpi[23:16]}, {24'h0, exp_ack});

    // ---------------- ack wrap ----------------
    while (exp_ack != 8'd255) send_cmd(3'd0, 4'd4, 24'd0);
    tick();
    check("ack_255", {24'h0, gpi[23:16]}, 32'd255);
    send_cmd(3'd0, 4'd4, 24'd0);
    tick();
    check("ack_wrap", {24'h0, gpi[23:16]}, 32'd0);

    // ---------------- async reset mid-blink ----------------
    sw = 4'b0001;
    repeat (14) tick();
    check("pre_reset_flag", {31'h0, gpi[8]}, 32'h1);
    check("pre_reset_blink", {31'h0, (led != 8'h0)}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", {24'h0, led}, 32'h0);
    check("async_reset_gpi", gpi, 32'h0);
    sw      = 4'b0000;
    tgl     = 1'b1;
    gpo     = 32'h8200_0001;
    exp_ack = 8'd1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("release_cmd_led", {24'h0, led}, 32'h04);
    check("release_cmd_gpi", gpi, {8'h0, exp_ack, 16'h0});
    repeat (3) tick();
    check("release_single_cmd", gpi, 32'h0001_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
